// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder with a 256-byte page buffer.
// Oversamples SCK/CS/MOSI on i_clk; supports WREN/WRDI/RDSR/ID/READ/PP/CE.
`timescale 1ns/1ps
module spi_flash_resp #(
  parameter logic [7:0] MFR_ID   = 8'hEF,
  parameter logic [7:0] DEV_ID   = 8'h17,
  parameter int         ERASE_CY = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sck,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic [7:0] o_cmd,
  output logic       o_cmd_vld,
  output logic       o_busy,
  output logic       o_wel,
  input  logic [7:0] i_dbg_addr,
  output logic [7:0] o_dbg_q
);

  localparam int ECW = $clog2(ERASE_CY + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
  } st_t;

  typedef enum logic [2:0] {
    A_NONE, A_WREN, A_WRDI, A_PP, A_CE
  } act_t;

  typedef enum logic [1:0] {
    S_SR, S_ID, S_BUF
  } src_t;

  logic [7:0]     mem [256];
  logic [2:0]     sck_sy;
  logic [2:0]     cs_sy;
  logic [1:0]     mosi_sy;
  st_t            st;
  act_t           act;
  src_t           src;
  logic [2:0]     bit_cnt;
  logic [1:0]     bcnt;
  logic [6:0]     sh;
  logic           wr_mode;
  logic [7:0]     ptr;
  logic [7:0]     tx_sh;
  logic [2:0]     tx_bit;
  logic [ECW-1:0] er_cnt;

  logic       sck_rise, sck_fall;
  logic       cs_rise, cs_fall;
  logic [7:0] rx_byte;
  logic [7:0] src_byte;
  logic       byte_done;
  logic       wdone;

  // [1] is the synchronized level, [2] its previous value
  assign sck_rise = sck_sy[1] & ~sck_sy[2];
  assign sck_fall = ~sck_sy[1] & sck_sy[2];
  assign cs_rise  = cs_sy[1] & ~cs_sy[2];
  assign cs_fall  = ~cs_sy[1] & cs_sy[2];
  assign rx_byte  = {sh, mosi_sy[1]};

  assign byte_done = sck_rise & ~cs_sy[1] & ~cs_fall
                   & (st != IDLE) & (bit_cnt == 3'd7);
  assign wdone     = byte_done & (st == WDATA);

  always_comb begin
    unique case (src)
      S_SR:    src_byte = {6'b0, o_wel, o_busy};
      S_ID:    src_byte = ptr[0] ? DEV_ID : MFR_ID;
      default: src_byte = mem[ptr];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (o_busy)
      mem[er_cnt[7:0]] <= 8'hFF;
    else if (wdone)
      mem[ptr] <= rx_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_sy    <= '0;
      cs_sy     <= '1;
      mosi_sy   <= '0;
      st        <= IDLE;
      act       <= A_NONE;
      src       <= S_SR;
      bit_cnt   <= '0;
      bcnt      <= '0;
      sh        <= '0;
      wr_mode   <= 1'b0;
      ptr       <= '0;
      tx_sh     <= '0;
      tx_bit    <= '0;
      er_cnt    <= '0;
      o_miso    <= 1'b0;
      o_miso_oe <= 1'b0;
      o_cmd     <= '0;
      o_cmd_vld <= 1'b0;
      o_busy    <= 1'b0;
      o_wel     <= 1'b0;
      o_dbg_q   <= '0;
    end else begin
      sck_sy    <= {sck_sy[1:0], i_sck};
      cs_sy     <= {cs_sy[1:0], i_cs_n};
      mosi_sy   <= {mosi_sy[0], i_mosi};
      o_cmd_vld <= 1'b0;
      o_dbg_q   <= mem[i_dbg_addr];

      if (o_busy) begin
        er_cnt <= er_cnt + ECW'(1);
        if (er_cnt == ECW'(ERASE_CY - 1)) begin
          o_busy <= 1'b0;
          o_wel  <= 1'b0;
        end
      end

      if (cs_rise) begin
        st        <= IDLE;
        act       <= A_NONE;
        o_miso    <= 1'b0;
        o_miso_oe <= 1'b0;
        unique case (act)
          A_WREN:       o_wel <= 1'b1;
          A_WRDI, A_PP: o_wel <= 1'b0;
          A_CE: begin
            o_busy <= 1'b1;
            er_cnt <= '0;
          end
          default: ;
        endcase
      end else if (cs_fall) begin
        st      <= CMD;
        act     <= A_NONE;
        bit_cnt <= '0;
        bcnt    <= '0;
      end else if (!cs_sy[1] && st != IDLE) begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          sh      <= rx_byte[6:0];
        end
        if (sck_fall && st == RDATA) begin
          o_miso <= tx_sh[7];
          tx_bit <= tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
            tx_sh <= src_byte;
            ptr   <= ptr + 8'd1;
          end else begin
            tx_sh <= {tx_sh[6:0], 1'b0};
          end
        end
        if (byte_done) begin
          unique case (1'b1)
            st == CMD: begin
              o_cmd     <= rx_byte;
              o_cmd_vld <= 1'b1;
              st        <= IGNORE;
              if (!o_busy || rx_byte == 8'h05) begin
                unique case (rx_byte)
                  8'h06: act <= A_WREN;
                  8'h04: act <= A_WRDI;
                  8'h05: begin
                    st        <= RDATA;
                    src       <= S_SR;
                    tx_sh     <= {6'b0, o_wel, o_busy};
                    tx_bit    <= '0;
                    o_miso_oe <= 1'b1;
                  end
                  8'h90: st <= DUMMY;
                  8'h03: begin
                    st      <= ADDR;
                    wr_mode <= 1'b0;
                  end
                  8'h02: if (o_wel) begin
                    st      <= ADDR;
                    wr_mode <= 1'b1;
                    act     <= A_PP;
                  end
                  8'h60: if (o_wel) act <= A_CE;
                  default: ;
                endcase
              end
            end
            st == ADDR: begin
              bcnt <= bcnt + 2'd1;
              if (bcnt == 2'd2) begin
                if (wr_mode) begin
                  st  <= WDATA;
                  ptr <= rx_byte;
                end else begin
                  st        <= RDATA;
                  src       <= S_BUF;
                  tx_sh     <= mem[rx_byte];
                  ptr       <= rx_byte + 8'd1;
                  tx_bit    <= '0;
                  o_miso_oe <= 1'b1;
                end
              end
            end
            st == DUMMY: begin
              bcnt <= bcnt + 2'd1;
              if (bcnt == 2'd1) begin
                st        <= RDATA;
                src       <= S_ID;
                tx_sh     <= MFR_ID;
                ptr       <= 8'd1;
                tx_bit    <= '0;
                o_miso_oe <= 1'b1;
              end
            end
            st == WDATA: ptr <= ptr + 8'd1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Bench for spi_flash_resp: vector table, directed corner cases,
// and random transactions against a transaction-level flash model.
`timescale 1ns/1ps
module tb_spi_flash_resp;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_sck;
  logic       i_cs_n;
  logic       i_mosi;
  logic       o_miso;
  logic       o_miso_oe;
  logic [7:0] o_cmd;
  logic       o_cmd_vld;
  logic       o_busy;
  logic       o_wel;
  logic [7:0] i_dbg_addr;
  logic [7:0] o_dbg_q;

  spi_flash_resp dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sck      (i_sck),
    .i_cs_n     (i_cs_n),
    .i_mosi     (i_mosi),
    .o_miso     (o_miso),
    .o_miso_oe  (o_miso_oe),
    .o_cmd      (o_cmd),
    .o_cmd_vld  (o_cmd_vld),
    .o_busy     (o_busy),
    .o_wel      (o_wel),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_q    (o_dbg_q)
  );

  always #5 i_clk = ~i_clk;

  localparam int HALF = 60;

  int checks = 0;
  int errors = 0;

  int vld_cnt = 0;
  int busy_run = 0;
  logic busy_q = 1'b0;

  always @(posedge i_clk) begin
    busy_q <= o_busy;
    if (o_cmd_vld) vld_cnt <= vld_cnt + 1;
    if (o_busy) busy_run <= busy_q ? busy_run + 1 : 1;
  end

  // flash model
  logic [7:0] m_mem [256];
  logic       m_wel;

  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  logic       hdr_oe, dat_oe_all, dat_oe_any;

  typedef struct {
    logic [7:0] op;
    logic [7:0] sr;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic xbits(input logic [7:0] tx, input int nb,
                       output logic [7:0] rx, output logic oe_all,
                       output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 0; i < nb; i++) begin
      i_mosi = tx[7-i];
      #HALF;
      rx = {rx[6:0], o_miso};
      oe_all &= o_miso_oe;
      oe_any |= o_miso_oe;
      i_sck = 1'b1;
      #HALF;
      i_sck = 1'b0;
    end
  endtask

  task automatic cs_lo();
    i_cs_n = 1'b0;
    #160;
  endtask

  task automatic cs_hi();
    #80;
    i_cs_n = 1'b1;
    #200;
  endtask

  task automatic run(input int nrd, input int part);
    logic [7:0] r;
    logic a, y;
    hdr_oe = 1'b0;
    dat_oe_all = 1'b1;
    dat_oe_any = 1'b0;
    rxq.delete();
    cs_lo();
    foreach (txq[i]) begin
      xbits(txq[i], 8, r, a, y);
      hdr_oe |= y;
    end
    for (int i = 0; i < nrd; i++) begin
      xbits(8'h00, 8, r, a, y);
      rxq.push_back(r);
      dat_oe_all &= a;
      dat_oe_any |= y;
    end
    if (part > 0) xbits(8'h5A, part, r, a, y);
    cs_hi();
  endtask

  task automatic dbg(input logic [7:0] a, output logic [7:0] q);
    @(negedge i_clk);
    i_dbg_addr = a;
    @(posedge i_clk);
    #1;
    q = o_dbg_q;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 2000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("busy_timeout", 32'(n < 2000), 1);
  endtask

  task automatic sweep(input string nm);
    logic [7:0] q;
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      dbg(8'(i), q);
      if (q !== m_mem[i]) bad++;
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q;
    int v0, k, a, n, part;
    logic [7:0] d;

    i_rst_n = 1'b0;
    i_sck = 1'b0;
    i_cs_n = 1'b1;
    i_mosi = 1'b0;
    i_dbg_addr = '0;
    m_wel = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;

    #33;
    chk("reset_outs",
        {o_miso, o_miso_oe, o_cmd, o_cmd_vld, o_busy, o_wel, o_dbg_q},
        '0);
    #20;
    i_rst_n = 1'b1;
    #100;

    // erase 1: READ issued while busy is ignored
    txq = '{8'h06}; run(0, 0);
    txq = '{8'h60}; run(0, 0);
    chk("ce_busy", o_busy, 1);
    txq = '{8'h03}; run(1, 0);
    chk("rd_busy_cmd", o_cmd, 8'h03);
    chk("rd_busy_oe", dat_oe_any, 0);
    wait_idle();

    // erase 2: status during and after, busy length
    txq = '{8'h06}; run(0, 0);
    txq = '{8'h60}; run(0, 0);
    txq = '{8'h05}; run(1, 0);
    chk("rdsr_busy", rxq[0], 8'h03);
    wait_idle();
    chk("busy_len", busy_run, 256);
    txq = '{8'h05}; run(1, 0);
    chk("rdsr_done", rxq[0], 8'h00);
    chk("wel_after_ce", o_wel, 0);
    sweep("erase_sweep");

    // single-byte ops followed by a status read
    tbl[0] = '{8'h06, 8'h02};
    tbl[1] = '{8'h04, 8'h00};
    tbl[2] = '{8'h06, 8'h02};
    tbl[3] = '{8'hAB, 8'h02};
    tbl[4] = '{8'h04, 8'h00};
    tbl[5] = '{8'h06, 8'h02};
    tbl[6] = '{8'h02, 8'h00};
    tbl[7] = '{8'h60, 8'h00};
    for (int i = 0; i < 8; i++) begin
      v0 = vld_cnt;
      txq = '{tbl[i].op}; run(0, 0);
      chk($sformatf("tbl%0d_cmd", i), o_cmd, tbl[i].op);
      txq = '{8'h05}; run(1, 0);
      chk($sformatf("tbl%0d_sr", i), rxq[0], tbl[i].sr);
      chk($sformatf("tbl%0d_vld", i), vld_cnt - v0, 2);
      chk($sformatf("tbl%0d_oe", i), dat_oe_all, 1);
    end

    // page program wrapping past FF
    txq = '{8'h06}; run(0, 0);
    txq = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    run(0, 0);
    m_mem[8'hFE] = 8'hAA;
    m_mem[8'hFF] = 8'hBB;
    m_mem[8'h00] = 8'hCC;
    chk("pp_wel", o_wel, 0);
    dbg(8'hFE, q); chk("pp_fe", q, 8'hAA);
    dbg(8'hFF, q); chk("pp_ff", q, 8'hBB);
    dbg(8'h00, q); chk("pp_00", q, 8'hCC);

    txq = '{8'h03, 8'h00, 8'h00, 8'hFF}; run(3, 0);
    chk("rd_b0", rxq[0], 8'hBB);
    chk("rd_b1", rxq[1], 8'hCC);
    chk("rd_b2", rxq[2], m_mem[1]);
    chk("rd_hdr_oe", hdr_oe, 0);
    chk("rd_dat_oe", dat_oe_all, 1);

    txq = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h55}; run(0, 0);
    dbg(8'h10, q); chk("pp_nowel", q, m_mem[8'h10]);

    txq = '{8'h90, 8'h00, 8'h00}; run(4, 0);
    chk("id0", rxq[0], 8'hEF);
    chk("id1", rxq[1], 8'h17);
    chk("id2", rxq[2], 8'hEF);
    chk("id3", rxq[3], 8'h17);

    // aborted transfers
    v0 = vld_cnt;
    cs_lo();
    xbits(8'h03, 8, q, hdr_oe, dat_oe_any);
    xbits(8'h00, 5, q, hdr_oe, dat_oe_any);
    cs_hi();
    chk("abort_vld", vld_cnt - v0, 1);
    txq = '{8'h03, 8'h00, 8'h00, 8'h00}; run(2, 0);
    chk("abort_rd0", rxq[0], m_mem[0]);
    chk("abort_rd1", rxq[1], m_mem[1]);
    cs_lo();
    xbits(8'h06, 3, q, hdr_oe, dat_oe_any);
    cs_hi();
    chk("abort_wren", o_wel, 0);

    // random transactions vs model
    for (int t = 0; t < 25; t++) begin
      k = $urandom_range(0, 5);
      a = $urandom_range(0, 255);
      n = $urandom_range(1, 4);
      case (k)
        0: begin
          txq = '{8'h06}; run(0, 0);
          m_wel = 1'b1;
        end
        1: begin
          txq = '{8'h04}; run(0, 0);
          m_wel = 1'b0;
        end
        2: begin
          txq = '{8'h05}; run(n, 0);
          for (int i = 0; i < n; i++)
            chk("r_rdsr", rxq[i], {6'b0, m_wel, 1'b0});
        end
        3: begin
          txq = '{8'h02, 8'($urandom), 8'($urandom), 8'(a)};
          part = $urandom_range(0, 7);
          for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            txq.push_back(d);
            if (m_wel) m_mem[(a + i) % 256] = d;
          end
          run(0, part);
          m_wel = 1'b0;
          chk("r_pp_wel", o_wel, 0);
        end
        4: begin
          txq = '{8'h03, 8'($urandom), 8'($urandom), 8'(a)};
          run(n, 0);
          for (int i = 0; i < n; i++)
            chk("r_read", rxq[i], m_mem[(a + i) % 256]);
          chk("r_read_oe", dat_oe_all, 1);
        end
        default: begin
          txq = '{8'h90, 8'($urandom), 8'($urandom)};
          run(n, 0);
          for (int i = 0; i < n; i++)
            chk("r_id", rxq[i], (i % 2) ? 8'h17 : 8'hEF);
        end
      endcase
    end
    sweep("final_sweep");

    // reset in the middle of a read data byte
    txq = '{8'h06}; run(0, 0);
    chk("pre_rst_wel", o_wel, 1);
    cs_lo();
    xbits(8'h03, 8, q, hdr_oe, dat_oe_any);
    for (int i = 0; i < 3; i++)
      xbits(8'h00, 8, q, hdr_oe, dat_oe_any);
    xbits(8'h00, 3, q, hdr_oe, dat_oe_any);
    chk("pre_rst_oe", o_miso_oe, 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_oe", o_miso_oe, 0);
    chk("rst_wel", o_wel, 0);
    chk("rst_cmd", o_cmd, 0);
    i_cs_n = 1'b1;
    #100;
    i_rst_n = 1'b1;
    #100;
    txq = '{8'h05}; run(1, 0);
    chk("post_rst_sr", rxq[0], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
